// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, redirect and multi-cycle sequencing controller for the five-stage core
module pipeline_ctrl #(
   parameter int XLEN       = 32,
   parameter int LU_BUBBLES = 1,
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_re_i,
   input  logic             id_rs2_re_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_is_load_i,
   input  logic             ex_branch_i,
   input  logic [XLEN-1:0]  ex_target_i,
   input  logic             ex_mc_req_i,
   input  logic             ex_mc_done_i,
   output logic             stall_front_o,
   output logic             stall_ex_o,
   output logic             bubble_ex_o,
   output logic             bubble_mem_o,
   output logic             flush_o,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             err_o
);

   localparam int TMO_W = $clog2(MC_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MC_WAIT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       lu_q, lu_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic hazard;
   logic stall_front, stall_ex, bubble_ex, bubble_mem, flush, redirect;

   // Load-use hazard: exe load writes a register that the id instruction reads (x0 never hazards)
   always_comb begin
      hazard = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
               ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));
   end

   // Next-state and strobe decode; branch beats mc_req beats hazard outside MC_WAIT
   always_comb begin
      state_d     = state_q;
      lu_d        = lu_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      stall_front = 1'b0;
      stall_ex    = 1'b0;
      bubble_ex   = 1'b0;
      bubble_mem  = 1'b0;
      flush       = 1'b0;
      redirect    = 1'b0;
      case (state_q)
         ST_RUN, ST_LU_STALL: begin
            if (ex_branch_i) begin
               // the branch is older than the stalled id instruction, so it cancels the stall
               redirect = 1'b1;
               flush    = 1'b1;
               state_d  = ST_RUN;
            end else if (ex_mc_req_i) begin
               stall_front = 1'b1;
               stall_ex    = 1'b1;
               bubble_mem  = 1'b1;
               state_d     = ST_MC_WAIT;
               tmo_d       = TMO_W'(1);
            end else if (state_q == ST_LU_STALL) begin
               stall_front = 1'b1;
               bubble_ex   = 1'b1;
               if (lu_q == 3'd1) begin
                  state_d = ST_RUN;
               end else begin
                  lu_d = lu_q - 3'd1;
               end
            end else if (hazard) begin
               stall_front = 1'b1;
               bubble_ex   = 1'b1;
               if (LU_BUBBLES > 1) begin
                  state_d = ST_LU_STALL;
                  lu_d    = 3'(LU_BUBBLES - 1);
               end
            end
         end
         ST_MC_WAIT: begin
            if (ex_mc_done_i) begin
               // result is ready: let exe advance this cycle
               state_d = ST_RUN;
            end else if (tmo_q == TMO_W'(MC_TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = ST_RUN;
            end else begin
               stall_front = 1'b1;
               stall_ex    = 1'b1;
               bubble_mem  = 1'b1;
               tmo_d       = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Saturating count of front-end stall cycles
   always_comb begin
      cnt_d = cnt_q;
      if (stall_front && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State, counters and sticky error register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
         lu_q    <= 3'd0;
         tmo_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lu_q    <= lu_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Outputs are forced quiet while reset is held so no redirect escapes mid-reset
   always_comb begin
      stall_front_o = rst_i & stall_front;
      stall_ex_o    = rst_i & stall_ex;
      bubble_ex_o   = rst_i & bubble_ex;
      bubble_mem_o  = rst_i & bubble_mem;
      flush_o       = rst_i & flush;
      redirect_o    = rst_i & redirect;
      redirect_pc_o = rst_i ? {ex_target_i[XLEN-1:1], 1'b0} : '0;
      stall_cnt_o   = cnt_q;
      err_o         = err_q;
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
   logic        id_rs1_re_i, id_rs2_re_i, ex_is_load_i, ex_branch_i, ex_mc_req_i, ex_mc_done_i;
   logic [31:0] ex_target_i;

   logic        a_sf, a_se, a_bex, a_bmem, a_fl, a_rd, a_err;
   logic [31:0] a_pc;
   logic [15:0] a_cnt;
   logic        b_sf, b_se, b_bex, b_bmem, b_fl, b_rd, b_err;
   logic [31:0] b_pc;
   logic [15:0] b_cnt;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   pipeline_ctrl #(.XLEN(32), .LU_BUBBLES(1), .MC_TIMEOUT(64), .CNT_W(16)) dut_a (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
      .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
      .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i),
      .ex_branch_i(ex_branch_i), .ex_target_i(ex_target_i),
      .ex_mc_req_i(ex_mc_req_i), .ex_mc_done_i(ex_mc_done_i),
      .stall_front_o(a_sf), .stall_ex_o(a_se), .bubble_ex_o(a_bex), .bubble_mem_o(a_bmem),
      .flush_o(a_fl), .redirect_o(a_rd), .redirect_pc_o(a_pc),
      .stall_cnt_o(a_cnt), .err_o(a_err)
   );

   pipeline_ctrl #(.XLEN(32), .LU_BUBBLES(3), .MC_TIMEOUT(4), .CNT_W(16)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
      .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
      .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i),
      .ex_branch_i(ex_branch_i), .ex_target_i(ex_target_i),
      .ex_mc_req_i(ex_mc_req_i), .ex_mc_done_i(ex_mc_done_i),
      .stall_front_o(b_sf), .stall_ex_o(b_se), .bubble_ex_o(b_bex), .bubble_mem_o(b_bmem),
      .flush_o(b_fl), .redirect_o(b_rd), .redirect_pc_o(b_pc),
      .stall_cnt_o(b_cnt), .err_o(b_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
      id_rs1_re_i   = 1'b0; id_rs2_re_i   = 1'b0;
      ex_rd_addr_i  = 5'd0; ex_is_load_i  = 1'b0;
      ex_branch_i   = 1'b0; ex_target_i   = 32'h0;
      ex_mc_req_i   = 1'b0; ex_mc_done_i  = 1'b0;
   endtask

   task automatic next_cycle();
      @(negedge clk_i);
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      idle();
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic lu_hazard_rs2_x5();
      ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd5;
      id_rs2_re_i  = 1'b1; id_rs2_addr_i = 5'd5;
   endtask

   initial begin
      idle();
      rst_i = 1'b0;
      ex_branch_i = 1'b1;
      ex_target_i = 32'hDEAD_BEEF;
      #12;
      // reset state: no strobes, zero PC, counters and error clear
      chk("rst_redirect", a_rd, 1'b0);
      chk("rst_flush", a_fl, 1'b0);
      chk("rst_pc", a_pc, 32'h0);
      chk("rst_cnt", a_cnt, 16'd0);
      chk("rst_err", b_err, 1'b0);
      @(negedge clk_i);
      idle();
      rst_i = 1'b1;

      // 1/2a: load-use on rs2, one bubble in dut_a, three in dut_b
      next_cycle(); lu_hazard_rs2_x5(); #1;
      chk("t1_a_sf", a_sf, 1'b1);
      chk("t1_a_bex", a_bex, 1'b1);
      chk("t1_a_se", a_se, 1'b0);
      chk("t1_b_sf0", b_sf, 1'b1);
      next_cycle(); #1;
      chk("t1_a_sf_off", a_sf, 1'b0);
      chk("t1_a_cnt", a_cnt, 16'd1);
      chk("t1_b_sf1", b_sf, 1'b1);
      chk("t1_b_bex1", b_bex, 1'b1);
      next_cycle(); #1;
      chk("t1_b_sf2", b_sf, 1'b1);
      next_cycle(); #1;
      chk("t1_b_sf_off", b_sf, 1'b0);
      chk("t1_b_cnt", b_cnt, 16'd3);

      // 2b: branch during the second load-use bubble aborts the stall
      do_reset();
      next_cycle(); lu_hazard_rs2_x5(); #1;
      chk("t2_b_sf0", b_sf, 1'b1);
      next_cycle(); ex_branch_i = 1'b1; ex_target_i = 32'h40; #1;
      chk("t2_b_sf_br", b_sf, 1'b0);
      chk("t2_b_flush", b_fl, 1'b1);
      chk("t2_b_redir", b_rd, 1'b1);
      chk("t2_b_pc", b_pc, 32'h40);
      next_cycle(); #1;
      chk("t2_b_sf_run", b_sf, 1'b0);
      chk("t2_b_flush_off", b_fl, 1'b0);
      chk("t2_b_cnt", b_cnt, 16'd1);

      // 3: x0 never hazards, unread operand never hazards, read rs1 does
      do_reset();
      next_cycle(); ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd0;
      id_rs1_re_i = 1'b1; id_rs1_addr_i = 5'd0; #1;
      chk("t3_x0", a_sf, 1'b0);
      next_cycle(); ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd7;
      id_rs1_re_i = 1'b0; id_rs1_addr_i = 5'd7; id_rs2_re_i = 1'b1; id_rs2_addr_i = 5'd3; #1;
      chk("t3_no_re", a_sf, 1'b0);
      id_rs1_re_i = 1'b1; #1;
      chk("t3_rs1_sf", a_sf, 1'b1);
      chk("t3_rs1_bex", a_bex, 1'b1);
      next_cycle(); #1;
      chk("t3_cnt", a_cnt, 16'd1);

      // 4: branch redirect clears bit 0 of target
      do_reset();
      next_cycle(); ex_branch_i = 1'b1; ex_target_i = 32'h0000_0103; #1;
      chk("t4_redir", a_rd, 1'b1);
      chk("t4_pc", a_pc, 32'h102);
      chk("t4_flush", a_fl, 1'b1);
      chk("t4_sf", a_sf, 1'b0);
      next_cycle(); #1;
      chk("t4_redir_off", a_rd, 1'b0);
      chk("t4_flush_off", a_fl, 1'b0);

      // 5: multi-cycle op, done arrives on the sixth cycle after the request
      do_reset();
      next_cycle(); ex_mc_req_i = 1'b1; #1;
      chk("t5_req_sf", a_sf, 1'b1);
      chk("t5_req_se", a_se, 1'b1);
      chk("t5_req_bmem", a_bmem, 1'b1);
      chk("t5_req_bex", a_bex, 1'b0);
      next_cycle(); #1;
      chk("t5_w1_sf", a_sf, 1'b1);
      next_cycle(); ex_branch_i = 1'b1; ex_target_i = 32'h80; lu_hazard_rs2_x5(); #1;
      chk("t5_w2_sf", a_sf, 1'b1);
      chk("t5_w2_redir_ign", a_rd, 1'b0);
      chk("t5_w2_flush_ign", a_fl, 1'b0);
      next_cycle();
      next_cycle();
      next_cycle(); #1;
      chk("t5_w5_se", a_se, 1'b1);
      next_cycle(); ex_mc_done_i = 1'b1; #1;
      chk("t5_done_sf", a_sf, 1'b0);
      chk("t5_done_se", a_se, 1'b0);
      chk("t5_done_bmem", a_bmem, 1'b0);
      next_cycle(); #1;
      chk("t5_cnt", a_cnt, 16'd6);
      chk("t5_err", a_err, 1'b0);
      chk("t5_run_sf", a_sf, 1'b0);

      // 6: timeout on dut_b (MC_TIMEOUT=4), then reset mid-wait
      do_reset();
      next_cycle(); ex_mc_req_i = 1'b1; #1;
      chk("t6_req_sf", b_sf, 1'b1);
      next_cycle(); #1; chk("t6_w1_sf", b_sf, 1'b1);
      next_cycle(); #1; chk("t6_w2_sf", b_sf, 1'b1);
      next_cycle(); #1; chk("t6_w3_sf", b_sf, 1'b1);
      next_cycle(); #1;
      chk("t6_tmo_sf", b_sf, 1'b0);
      chk("t6_tmo_err_pre", b_err, 1'b0);
      next_cycle(); ex_mc_done_i = 1'b1; ex_branch_i = 1'b1; ex_target_i = 32'h10; #1;
      chk("t6_err", b_err, 1'b1);
      chk("t6_cnt", b_cnt, 16'd4);
      chk("t6_run_flush", b_fl, 1'b1);
      chk("t6_run_sf", b_sf, 1'b0);
      next_cycle(); ex_mc_req_i = 1'b1; #1;
      chk("t6_req2_sf", b_sf, 1'b1);
      next_cycle(); ex_target_i = 32'h44; #1;
      chk("t6_wait2_sf", b_sf, 1'b1);
      #2 rst_i = 1'b0; #1;
      chk("t6_rst_sf", b_sf, 1'b0);
      chk("t6_rst_err", b_err, 1'b0);
      chk("t6_rst_cnt", b_cnt, 16'd0);
      chk("t6_rst_pc", b_pc, 32'h0);
      chk("t6_rst_redir", b_rd, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      next_cycle(); #1;
      chk("t6_after_sf", b_sf, 1'b0);
      chk("t6_after_cnt", b_cnt, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
